eau_load_sched: RTL and testbench
=================================

// Module: eau_load_sched
// PURPOSE
//  Scheduler for the external address unit (8-bit data in, 16-bit address out).
//  Arbitrates NREQ requesters round-robin and loads the winner's 16-bit address
//  into the EAU over its 8-bit bus: low byte (ls), then high byte (hs).
//  Asserts ao to drive the address until the owner releases it.
//  Sits between the bus masters (fetch, DMA, ...) and the EAU register pair.
// PARAMETERS
//  NREQ   2   number of requesters, 1..8
// PORTS
//  clk       in   1        system clock, rising edge
//  rst_n     in   1        asynchronous, active-low reset
//  req       in   NREQ     request lines, level
//  req_addr  in   16*NREQ  packed addresses; requester i at [16*i+15:16*i]
//  rel       in   NREQ     release pulse from owner; ends the grant
//  inc       in   NREQ     increment pulse from owner (used only with macro)
//  gnt       out  NREQ     one-hot grant, registered
//  bus_d     out  8        byte to EAU data input
//  bus_ls    out  1        EAU low-byte load strobe
//  bus_hs    out  1        EAU high-byte load strobe
//  bus_ao    out  1        EAU address output enable
//  busy      out  1        high in any state other than IDLE
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset values: state IDLE; gnt=0; bus_d=8'h00; bus_ls=0; bus_hs=0; bus_ao=0;
//    busy=0; round-robin pointer=0; shadow address=16'h0000.
//  - IDLE: when any req bit is high, pick the first set bit at or after the pointer
//    (wrapping modulo NREQ).
//    - Copy the winner's req_addr into a 16-bit shadow, set gnt one-hot, go to LOAD_LO.
//    - With no requests, stay in IDLE; all outputs hold their reset values.
//  - LOAD_LO (1 cycle): bus_d=shadow[7:0], bus_ls=1 -> LOAD_HI.
//  - LOAD_HI (1 cycle): bus_d=shadow[15:8], bus_hs=1 -> HOLD.
//  - HOLD: bus_ao=1, bus_d=0, no strobes.
//    - rel[owner] sampled high -> IDLE; gnt=0 and bus_ao=0 on the next cycle.
//    - Pointer becomes (owner+1) mod NREQ.
//  - Latency: req seen at edge k -> gnt and bus_ls in cycle k+1, bus_hs in k+2,
//    bus_ao from k+3.
//  - At most one strobe per cycle; bus_ls and bus_hs never both high.
//  - bus_ao is never high while a strobe is high.
//  - bus_d=0 outside the strobe cycles.
//  - rel is honoured only in HOLD and only from the owner; all other rel bits are ignored.
//  - Owner dropping req while granted has no effect; only rel ends the grant.
//  - Release plus a pending request from another requester: one IDLE cycle, then
//    the new grant. There is always at least one idle cycle between grants.
//  - req_addr changes after capture are ignored; the shadow is the source.
//  - NREQ=1: the pointer stays 0; behaviour is otherwise identical.
//  - Reset mid-operation clears all state and outputs immediately (asynchronously).
//    An interrupted grant is lost; the requester must re-request.
// CONFIGURATION
//  EAU_SCHED_AUTOINC_EN defined: an inc[owner] pulse in HOLD sets shadow to shadow+1,
//  wrapping 16'hFFFF->16'h0000.
//    - Go to INC_LO: bus_ao=0, bus_ls=1, bus_d=new shadow[7:0].
//    - If the new low byte is 8'h00 (carry), go to INC_HI: bus_hs=1,
//      bus_d=new shadow[15:8].
//    - Then return to HOLD (bus_ao=1).
//    - rel and inc in the same cycle: rel wins and inc is dropped.
//    - inc outside HOLD, or from a non-owner, is ignored.
//  Not defined: the inc port exists but is ignored; INC states are not built.
// TESTING
//  1. req=01, addr0=16'h1234 -> gnt=01; next cycle ls with bus_d=34;
//     next hs with bus_d=12; then ao=1 until rel[0]; then ao=0, gnt=00.
//  2. After reset, req=11, addr0=16'hA5A5, addr1=16'hBEEF -> requester 0 served first.
//     rel[0] -> one idle cycle, then gnt=10 with ls=EF, hs=BE.
//  3. req0 and req1 held continuously, each owner releasing after 2 HOLD cycles
//     -> grants alternate 01,10,01,10.
//  4. rst_n low during LOAD_HI -> all outputs 0 asynchronously.
//     After rst_n goes high, IDLE; with req=10 pending, requester 1 is granted.
//  5. AUTOINC: addr 16'h12FF, inc in HOLD -> ls with bus_d=00, then hs with
//     bus_d=13, then ao=1. From 16'h1200, inc -> ls with bus_d=01 only, no hs.
//  6. In HOLD for owner 0: rel[1] -> ignored, ao stays 1.
//     rel[0] and inc[0] in the same cycle -> released, no strobe.

Source files
------------

// File: rtl/eau_load_sched.sv
// eau_load_sched: round-robin scheduler that loads a 16-bit address into the
// external address unit over its 8-bit bus (low byte, then high byte) and
// holds the address output enabled until the owner releases it.
//
// Optional feature: define EAU_SCHED_AUTOINC_EN to let the owner post-increment
// the held address with an inc pulse. The EAU is reloaded with the new low byte,
// and with the new high byte only when the low byte carries out.
//
// Ports:
//   clk       system clock, rising edge
//   rst_n     asynchronous active-low reset
//   req       request lines, level, one per requester
//   req_addr  packed addresses, requester i at [16*i+15:16*i]
//   rel       release pulse from the owner
//   inc       increment pulse from the owner (autoinc build only)
//   gnt       registered one-hot grant
//   bus_d     byte to the EAU data input
//   bus_ls    EAU low-byte load strobe
//   bus_hs    EAU high-byte load strobe
//   bus_ao    EAU address output enable
//   busy      high whenever the scheduler is not idle
module eau_load_sched #(
  parameter int unsigned NREQ = 2
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic [NREQ-1:0]      req,
  input  logic [16*NREQ-1:0]   req_addr,
  input  logic [NREQ-1:0]      rel,
  input  logic [NREQ-1:0]      inc,
  output logic [NREQ-1:0]      gnt,
  output logic [7:0]           bus_d,
  output logic                 bus_ls,
  output logic                 bus_hs,
  output logic                 bus_ao,
  output logic                 busy
);

  localparam int unsigned PtrW = (NREQ > 1) ? $clog2(NREQ) : 1;

  typedef enum logic [2:0] {
    StIdle,
    StLoadLo,
    StLoadHi,
    StHold,
    StIncLo,
    StIncHi
  } state_e;

  state_e          state_q;
  logic [PtrW-1:0] ptr_q;
  logic [PtrW-1:0] owner_q;
  logic [15:0]     shadow_q;

  // Round-robin pick: first set request at or after the pointer, wrapping.
  logic            pick_found;
  logic [PtrW-1:0] pick_idx;
  logic [NREQ-1:0] pick_onehot;
  logic [15:0]     pick_addr;

  always_comb begin
    int unsigned idx;
    idx         = 0;
    pick_found  = 1'b0;
    pick_idx    = '0;
    pick_onehot = '0;
    pick_addr   = '0;
    for (int unsigned k = 0; k < NREQ; k++) begin
      idx = (int'(ptr_q) + k) % NREQ;
      if (!pick_found && req[idx]) begin
        pick_found       = 1'b1;
        pick_idx         = PtrW'(idx);
        pick_onehot[idx] = 1'b1;
        pick_addr        = req_addr[16*idx +: 16];
      end
    end
  end

  // Grant is one-hot, so masking with it selects the owner's bit only.
  logic rel_own;
  assign rel_own = |(rel & gnt);

  logic [PtrW-1:0] ptr_after_owner;
  assign ptr_after_owner = (owner_q == PtrW'(NREQ - 1)) ? '0 : owner_q + 1'b1;

`ifdef EAU_SCHED_AUTOINC_EN
  logic        inc_own;
  logic [15:0] shadow_inc;
  assign inc_own    = |(inc & gnt);
  assign shadow_inc = shadow_q + 16'd1;
`else
  logic unused_inc;
  assign unused_inc = ^inc;
`endif

  // Outputs are registered on entry to each state, so they are valid for the
  // whole cycle that the state occupies.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      ptr_q    <= '0;
      owner_q  <= '0;
      shadow_q <= 16'h0000;
      gnt      <= '0;
      bus_d    <= 8'h00;
      bus_ls   <= 1'b0;
      bus_hs   <= 1'b0;
      bus_ao   <= 1'b0;
      busy     <= 1'b0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (pick_found) begin
            state_q  <= StLoadLo;
            owner_q  <= pick_idx;
            shadow_q <= pick_addr;
            gnt      <= pick_onehot;
            bus_d    <= pick_addr[7:0];
            bus_ls   <= 1'b1;
            busy     <= 1'b1;
          end
        end
        StLoadLo: begin
          state_q <= StLoadHi;
          bus_ls  <= 1'b0;
          bus_hs  <= 1'b1;
          bus_d   <= shadow_q[15:8];
        end
        StLoadHi: begin
          state_q <= StHold;
          bus_hs  <= 1'b0;
          bus_d   <= 8'h00;
          bus_ao  <= 1'b1;
        end
        StHold: begin
          // Release has priority over increment.
          if (rel_own) begin
            state_q <= StIdle;
            gnt     <= '0;
            bus_ao  <= 1'b0;
            busy    <= 1'b0;
            ptr_q   <= ptr_after_owner;
`ifdef EAU_SCHED_AUTOINC_EN
          end else if (inc_own) begin
            state_q  <= StIncLo;
            shadow_q <= shadow_inc;
            bus_ao   <= 1'b0;
            bus_ls   <= 1'b1;
            bus_d    <= shadow_inc[7:0];
`endif
          end
        end
`ifdef EAU_SCHED_AUTOINC_EN
        StIncLo: begin
          bus_ls <= 1'b0;
          if (shadow_q[7:0] == 8'h00) begin
            state_q <= StIncHi;
            bus_hs  <= 1'b1;
            bus_d   <= shadow_q[15:8];
          end else begin
            state_q <= StHold;
            bus_d   <= 8'h00;
            bus_ao  <= 1'b1;
          end
        end
        StIncHi: begin
          state_q <= StHold;
          bus_hs  <= 1'b0;
          bus_d   <= 8'h00;
          bus_ao  <= 1'b1;
        end
`endif
        default: begin
          state_q <= StIdle;
          gnt     <= '0;
          bus_d   <= 8'h00;
          bus_ls  <= 1'b0;
          bus_hs  <= 1'b0;
          bus_ao  <= 1'b0;
          busy    <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_eau_load_sched.sv
// Directed testbench for eau_load_sched (NREQ=2). Inputs change 1 time unit
// after each rising edge; outputs are checked at the same point.
module tb_eau_load_sched;

  localparam int unsigned NREQ = 2;

  logic                clk;
  logic                rst_n;
  logic [NREQ-1:0]     req;
  logic [16*NREQ-1:0]  req_addr;
  logic [NREQ-1:0]     rel;
  logic [NREQ-1:0]     inc;
  logic [NREQ-1:0]     gnt;
  logic [7:0]          bus_d;
  logic                bus_ls;
  logic                bus_hs;
  logic                bus_ao;
  logic                busy;

  int n_tests = 0;
  int n_fail  = 0;

  eau_load_sched #(.NREQ(NREQ)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .req      (req),
    .req_addr (req_addr),
    .rel      (rel),
    .inc      (inc),
    .gnt      (gnt),
    .bus_d    (bus_d),
    .bus_ls   (bus_ls),
    .bus_hs   (bus_hs),
    .bus_ao   (bus_ao),
    .busy     (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Packs {gnt, ls, hs, ao, busy, bus_d} for compact whole-bus checks.
  function automatic logic [31:0] outs();
    return {18'd0, gnt, bus_ls, bus_hs, bus_ao, busy, bus_d};
  endfunction

  function automatic logic [31:0] exp_outs(input logic [1:0] g, input logic ls, input logic hs,
                                           input logic ao, input logic bz, input logic [7:0] d);
    return {18'd0, g, ls, hs, ao, bz, d};
  endfunction

  task automatic do_reset();
    rst_n    = 1'b0;
    req      = '0;
    req_addr = '0;
    rel      = '0;
    inc      = '0;
    step();
    step();
    rst_n = 1'b1;
  endtask

  initial begin
    do_reset();
    check_eq("reset_outs", outs(), exp_outs(2'b00, 0, 0, 0, 0, 8'h00));
    step();
    check_eq("idle_no_req", outs(), exp_outs(2'b00, 0, 0, 0, 0, 8'h00));

    // 1: single requester, full load and release
    req = 2'b01;
    req_addr[15:0] = 16'h1234;
    step();
    check_eq("t1_lo", outs(), exp_outs(2'b01, 1, 0, 0, 1, 8'h34));
    req_addr[15:0] = 16'hFFFF;  // must be ignored after capture
    step();
    check_eq("t1_hi", outs(), exp_outs(2'b01, 0, 1, 0, 1, 8'h12));
    step();
    check_eq("t1_hold", outs(), exp_outs(2'b01, 0, 0, 1, 1, 8'h00));
    req = 2'b00;  // dropping req while owner has no effect
    step();
    check_eq("t1_hold2", outs(), exp_outs(2'b01, 0, 0, 1, 1, 8'h00));
    rel = 2'b01;
    step();
    rel = 2'b00;
    check_eq("t1_rel", outs(), exp_outs(2'b00, 0, 0, 0, 0, 8'h00));

    // 2: both request, 0 first, then 1 after one idle cycle
    do_reset();
    req = 2'b11;
    req_addr = {16'hBEEF, 16'hA5A5};
    step();
    check_eq("t2_g0_lo", outs(), exp_outs(2'b01, 1, 0, 0, 1, 8'hA5));
    step();
    step();
    check_eq("t2_g0_hold", outs(), exp_outs(2'b01, 0, 0, 1, 1, 8'h00));
    rel = 2'b01;
    step();
    rel = 2'b00;
    check_eq("t2_idle_gap", outs(), exp_outs(2'b00, 0, 0, 0, 0, 8'h00));
    step();
    check_eq("t2_g1_lo", outs(), exp_outs(2'b10, 1, 0, 0, 1, 8'hEF));
    step();
    check_eq("t2_g1_hi", outs(), exp_outs(2'b10, 0, 1, 0, 1, 8'hBE));
    step();
    check_eq("t2_g1_hold", outs(), exp_outs(2'b10, 0, 0, 1, 1, 8'h00));
    rel = 2'b10;
    req = 2'b00;
    step();
    rel = 2'b00;
    check_eq("t2_rel", outs(), exp_outs(2'b00, 0, 0, 0, 0, 8'h00));

    // 3: continuous requests alternate grants
    do_reset();
    req = 2'b11;
    req_addr = {16'h2222, 16'h1111};
    begin
      logic [1:0] exp_g [4];
      exp_g = '{2'b01, 2'b10, 2'b01, 2'b10};
      for (int i = 0; i < 4; i++) begin
        step();
        check_eq($sformatf("t3_gnt%0d", i), {30'd0, gnt}, {30'd0, exp_g[i]});
        step();
        step();
        step();
        rel = exp_g[i];
        step();
        rel = 2'b00;
        check_eq($sformatf("t3_idle%0d", i), {30'd0, gnt}, 32'd0);
      end
    end
    req = 2'b00;

    // 4: asynchronous reset during LOAD_HI
    do_reset();
    req = 2'b01;
    req_addr = {16'h0000, 16'hFFFF};
    step();
    step();
    check_eq("t4_in_hi", outs(), exp_outs(2'b01, 0, 1, 0, 1, 8'hFF));
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("t4_async_rst", outs(), exp_outs(2'b00, 0, 0, 0, 0, 8'h00));
    req = 2'b10;
    #1;
    rst_n = 1'b1;
    step();
    check_eq("t4_after_rst", outs(), exp_outs(2'b10, 1, 0, 0, 1, 8'h00));
    step();
    step();
    rel = 2'b10;
    req = 2'b00;
    step();
    rel = 2'b00;

    // 6: non-owner release ignored; rel wins over inc
    do_reset();
    req = 2'b01;
    req_addr = {16'h0000, 16'h4321};
    step();
    step();
    step();
    req = 2'b00;
    rel = 2'b10;
    step();
    check_eq("t6_foreign_rel", outs(), exp_outs(2'b01, 0, 0, 1, 1, 8'h00));
    rel = 2'b01;
    inc = 2'b01;
    step();
    rel = 2'b00;
    inc = 2'b00;
    check_eq("t6_rel_inc", outs(), exp_outs(2'b00, 0, 0, 0, 0, 8'h00));
    step();
    check_eq("t6_no_strobe", outs(), exp_outs(2'b00, 0, 0, 0, 0, 8'h00));

`ifdef EAU_SCHED_AUTOINC_EN
    // 5: post-increment with and without carry into the high byte
    do_reset();
    req = 2'b01;
    req_addr = {16'h0000, 16'h12FF};
    step();
    step();
    step();
    req = 2'b00;
    inc = 2'b01;
    step();
    inc = 2'b00;
    check_eq("t5_inc_lo", outs(), exp_outs(2'b01, 1, 0, 0, 1, 8'h00));
    step();
    check_eq("t5_inc_hi", outs(), exp_outs(2'b01, 0, 1, 0, 1, 8'h13));
    step();
    check_eq("t5_inc_hold", outs(), exp_outs(2'b01, 0, 0, 1, 1, 8'h00));
    rel = 2'b01;
    step();
    rel = 2'b00;
    req = 2'b01;
    req_addr = {16'h0000, 16'h1200};
    step();
    step();
    step();
    req = 2'b00;
    inc = 2'b01;
    step();
    inc = 2'b00;
    check_eq("t5b_inc_lo", outs(), exp_outs(2'b01, 1, 0, 0, 1, 8'h01));
    step();
    check_eq("t5b_no_hi", outs(), exp_outs(2'b01, 0, 0, 1, 1, 8'h00));
    rel = 2'b01;
    step();
    rel = 2'b00;
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
